step_decoder: RTL and testbench

- Passive monitor on the 4-bit half-step coil bus driven to the ULN2003; the decoder side of the platform stepper sequencer.
- Recovers step events and direction from coil-pattern transitions and keeps a signed platform position, homed by the lower limit switch.
- Flags skipped-phase and overtravel faults for the house controller and status display.

---
 rtl/platform_pkg.sv | 21 ++
 rtl/step_pattern_lut.sv | 26 ++
 rtl/step_decoder.sv | 142 ++++++++++++++
 tb/tb_step_decoder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/platform_pkg.sv
// Shared definitions for the platform stepper: half-step coil patterns and decoder state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package platform_pkg;

    localparam int IDX_W    = 3;
    localparam int N_PHASES = 8;

    // Half-step coil sequence {IN4,IN3,IN2,IN1}, index order = up direction.
    // The sequencer drives this same table, so encode and decode stay in lockstep.
    localparam logic [3:0] HALF_STEP [N_PHASES] = '{
        4'b1000, 4'b1100, 4'b0100, 4'b0110,
        4'b0010, 4'b0011, 4'b0001, 4'b1001
    };

    typedef enum logic {
        UNLOCKED = 1'b0,
        TRACK    = 1'b1
    } dec_state_e;

endpackage

// File: rtl/step_pattern_lut.sv
// Maps a 4-bit coil pattern to its half-step phase index; flags de-energized and illegal patterns.
// Latency: combinational.
// Backpressure: none (pure function of the input).
// Ports: pattern in; valid (pattern is a sequence phase), idle (all coils off), idx (phase 0..7).
module step_pattern_lut
    import platform_pkg::*;
(
    input  logic [3:0]       pattern,
    output logic             valid,
    output logic             idle,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        idle  = (pattern == 4'b0000);
        for (int i = 0; i < N_PHASES; i++) begin
            if (pattern == HALF_STEP[i]) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/step_decoder.sv
// Passive coil-bus monitor: decodes half-step transitions into steps, tracks signed position, flags faults.
// Latency: 2 cycles from a step_in change to step_pulse/position (input register + registered outputs).
// Backpressure: none; observes the bus every cycle and can never stall it.
// Ports: clk, rst_n (async, active low); step_in coil pattern; stop_up/stop_down limit switches (active low);
//        pos_clr, err_clr controls; position, step_pulse, dir_up, moving, homed, err_skip, err_overtravel status.
module step_decoder
    import platform_pkg::*;
#(
    parameter int POS_WIDTH   = 16,
    parameter int IDLE_CYCLES = 1_000_000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [3:0]                  step_in,
    input  logic                        stop_up,
    input  logic                        stop_down,
    input  logic                        pos_clr,
    input  logic                        err_clr,
    output logic signed [POS_WIDTH-1:0] position,
    output logic                        step_pulse,
    output logic                        dir_up,
    output logic                        moving,
    output logic                        homed,
    output logic                        err_skip,
    output logic                        err_overtravel
);

    localparam int CNT_W = $clog2(IDLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic signed [POS_WIDTH-1:0] POS_MAX = {1'b0, {(POS_WIDTH-1){1'b1}}};
    localparam logic signed [POS_WIDTH-1:0] POS_MIN = {1'b1, {(POS_WIDTH-1){1'b0}}};

    logic [3:0]       in_q;
    dec_state_e       state_q, state_d;
    logic [IDX_W-1:0] prev_idx_q, prev_idx_d;
    logic [CNT_W-1:0] idle_cnt;

    logic             lut_valid, lut_idle;
    logic [IDX_W-1:0] lut_idx;
    logic [IDX_W-1:0] delta;
    logic             step_up, step_dn, skip;

    step_pattern_lut u_lut (
        .pattern (in_q),
        .valid   (lut_valid),
        .idle    (lut_idle),
        .idx     (lut_idx)
    );

    // Stage 1: register the coil bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) in_q <= 4'b0000;
        else        in_q <= step_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= UNLOCKED;
            prev_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            prev_idx_q <= prev_idx_d;
        end
    end

    // Stage 2: classify the registered pattern against the last locked phase.
    always_comb begin
        state_d    = state_q;
        prev_idx_d = prev_idx_q;
        delta      = '0;
        step_up    = 1'b0;
        step_dn    = 1'b0;
        skip       = 1'b0;
        if (!lut_valid && !lut_idle) begin
            // Not a sequence phase: lock is untrustworthy from here on.
            skip    = 1'b1;
            state_d = UNLOCKED;
        end else if (lut_valid) begin
            case (state_q)
                UNLOCKED: begin
                    prev_idx_d = lut_idx;
                    state_d    = TRACK;
                end
                TRACK: begin
                    // 3-bit subtraction gives the modulo-8 phase distance directly.
                    delta = lut_idx - prev_idx_q;
                    if (delta == 3'd1) begin
                        step_up    = 1'b1;
                        prev_idx_d = lut_idx;
                    end else if (delta == 3'd7) begin
                        step_dn    = 1'b1;
                        prev_idx_d = lut_idx;
                    end else if (delta != 3'd0) begin
                        // Jumped phases: resync to the new phase but count nothing.
                        skip       = 1'b1;
                        prev_idx_d = lut_idx;
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            position       <= '0;
            step_pulse     <= 1'b0;
            dir_up         <= 1'b0;
            moving         <= 1'b0;
            homed          <= 1'b0;
            err_skip       <= 1'b0;
            err_overtravel <= 1'b0;
            idle_cnt       <= '0;
        end else begin
            step_pulse <= step_up | step_dn;
            if (step_up | step_dn) dir_up <= step_up;

            // Clear beats the limit reference, which beats counting.
            if (pos_clr)                               position <= '0;
            else if (!stop_down)                       position <= '0;
            else if (step_up && position != POS_MAX)   position <= position + 1'b1;
            else if (step_dn && position != POS_MIN)   position <= position - 1'b1;

            if (!stop_down) homed <= 1'b1;

            // Set terms OR in after the clear so a same-cycle event is not lost.
            err_skip       <= (err_skip & ~err_clr) | skip;
            err_overtravel <= (err_overtravel & ~err_clr)
                              | (step_up & ~stop_up) | (step_dn & ~stop_down);

            if (step_up | step_dn) begin
                moving   <= 1'b1;
                idle_cnt <= '0;
            end else if (idle_cnt != CNT_MAX) begin
                idle_cnt <= idle_cnt + 1'b1;
                if (idle_cnt == CNT_LAST) moving <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_step_decoder.sv
module tb_step_decoder;

    logic               clk;
    logic               rst_n;
    logic [3:0]         step_in;
    logic               stop_up;
    logic               stop_down;
    logic               pos_clr;
    logic               err_clr;
    logic signed [15:0] position;
    logic               step_pulse;
    logic               dir_up;
    logic               moving;
    logic               homed;
    logic               err_skip;
    logic               err_overtravel;

    step_decoder #(
        .POS_WIDTH   (16),
        .IDLE_CYCLES (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .step_in        (step_in),
        .stop_up        (stop_up),
        .stop_down      (stop_down),
        .pos_clr        (pos_clr),
        .err_clr        (err_clr),
        .position       (position),
        .step_pulse     (step_pulse),
        .dir_up         (dir_up),
        .moving         (moving),
        .homed          (homed),
        .err_skip       (err_skip),
        .err_overtravel (err_overtravel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] pat_tbl [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a pattern and watch step_pulse for `hold` cycles; first = cycle index of the first pulse.
    task automatic apply(input logic [3:0] p, input int hold, output int np, output int first);
        np      = 0;
        first   = 0;
        step_in = p;
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            if (step_pulse) begin
                np++;
                if (first == 0) first = i;
            end
        end
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        int np, first, cur, nmov, first_mov;
        pat_tbl = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                    4'b0010, 4'b0011, 4'b0001, 4'b1001};
        rst_n = 1'b0; step_in = 4'b0000; stop_up = 1'b1; stop_down = 1'b1;
        pos_clr = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_position", 32'(position), 0);
        check("rst_flags", {step_pulse, dir_up, moving, homed, err_skip, err_overtravel}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Up run: first pattern only locks.
        apply(4'b1000, 10, np, first);
        check("lock_no_count", np, 0);
        apply(4'b1100, 10, np, first);
        check("up1_pulses", np, 1);
        check("up1_latency", first, 2);
        apply(4'b0100, 10, np, first);
        check("up2_latency", first, 2);
        apply(4'b0110, 10, np, first);
        check("up3_pulses", np, 1);
        check("up_position", 32'(position), 3);
        check("up_dir", dir_up, 1);
        check("up_no_err", err_skip, 0);

        // Down run across the 0->7 wrap.
        np = 0;
        for (int k = 0; k < 5; k++) begin
            int n1;
            logic [3:0] dn_pats [5];
            dn_pats = '{4'b0100, 4'b1100, 4'b1000, 4'b1001, 4'b0001};
            apply(dn_pats[k], 4, n1, first);
            np += n1;
        end
        check("down_pulses", np, 5);
        check("down_position", 32'(position), -2);
        check("down_dir", dir_up, 0);

        // Reach 1000 (idx 0), then a delta-4 jump.
        apply(4'b1001, 4, np, first);
        apply(4'b1000, 4, np, first);
        check("pos_at_zero", 32'(position), 0);
        apply(4'b0010, 4, np, first);
        check("skip_no_pulse", np, 0);
        check("skip_flag", err_skip, 1);
        check("skip_pos", 32'(position), 0);
        apply(4'b0011, 4, np, first);
        check("after_skip_count", np, 1);
        check("after_skip_pos", 32'(position), 1);
        pulse_err_clr();
        check("err_clr_skip", err_skip, 0);
        // Fresh skip (idx5 -> idx0) lands on the same edge as err_clr.
        step_in = 4'b1000;
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("set_wins_clr", err_skip, 1);
        pulse_err_clr();

        // De-energized gap keeps the lock.
        apply(4'b0000, 4, np, first);
        check("idle_no_pulse", np, 0);
        check("idle_no_err", err_skip, 0);
        apply(4'b1100, 4, np, first);
        check("idle_then_step", np, 1);
        check("idle_step_pos", 32'(position), 2);
        apply(4'b1111, 4, np, first);
        check("illegal_flag", err_skip, 1);
        apply(4'b0110, 4, np, first);
        check("relock_no_count", np, 0);
        check("relock_pos", 32'(position), 2);
        apply(4'b0010, 4, np, first);
        check("relock_then_step", np, 1);

        // Homing and overtravel.
        apply(4'b0011, 4, np, first);
        apply(4'b0001, 4, np, first);
        check("pre_home_pos", 32'(position), 5);
        check("pre_home_homed", homed, 0);
        stop_down = 1'b0;
        @(negedge clk);
        check("home_pos", 32'(position), 0);
        check("home_flag", homed, 1);
        apply(4'b0011, 4, np, first);
        check("ot_down_pulse", np, 1);
        check("ot_down_flag", err_overtravel, 1);
        check("ot_down_pos", 32'(position), 0);
        stop_down = 1'b1;
        pulse_err_clr();
        check("ot_cleared", err_overtravel, 0);
        stop_up = 1'b0;
        apply(4'b0001, 4, np, first);
        check("ot_up_flag", err_overtravel, 1);
        check("ot_up_pos", 32'(position), 1);
        stop_up = 1'b1;
        check("homed_sticky", homed, 1);

        // moving: high for exactly IDLE_CYCLES cycles after a step.
        repeat (20) @(negedge clk);
        check("moving_idle", moving, 0);
        step_in   = 4'b1001;
        nmov      = 0;
        first_mov = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (moving) begin
                nmov++;
                if (first_mov == 0) first_mov = i;
            end
        end
        check("moving_cycles", nmov, 8);
        check("moving_start", first_mov, 2);
        cur = 7;

        // Saturation at signed max.
        pos_clr = 1'b1;
        @(negedge clk);
        pos_clr = 1'b0;
        check("pos_clr", 32'(position), 0);
        pulse_err_clr();
        for (int i = 0; i < 32767; i++) begin
            cur = (cur + 1) % 8;
            step_in = pat_tbl[cur];
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("reach_max", 32'(position), 32767);
        check("fast_no_skip", err_skip, 0);
        cur = (cur + 1) % 8;
        apply(pat_tbl[cur], 4, np, first);
        check("sat_pulse", np, 1);
        check("sat_pos", 32'(position), 32767);

        // pos_clr beats a simultaneous step.
        cur = (cur + 1) % 8;
        step_in = pat_tbl[cur];
        @(negedge clk);
        pos_clr = 1'b1;
        @(negedge clk);
        check("clr_step_pulse", step_pulse, 1);
        check("clr_step_pos", 32'(position), 0);
        pos_clr = 1'b0;

        // Reset mid-motion drops the lock.
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_flags", {step_pulse, dir_up, moving, homed, err_skip, err_overtravel}, 0);
        rst_n = 1'b1;
        cur = (cur + 1) % 8;
        apply(pat_tbl[cur], 4, np, first);
        check("post_rst_relock", np, 0);
        check("post_rst_pos", 32'(position), 0);
        cur = (cur + 1) % 8;
        apply(pat_tbl[cur], 4, np, first);
        check("post_rst_step", 32'(position), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
